// File: rtl/codec_cfg_pkg.sv
// Shared types and the WM8731 boot table for the codec configuration sequencer.
package codec_cfg_pkg;

    localparam int unsigned NUM_REGS = 10;

    localparam logic [6:0] R_LLIN   = 7'h00;
    localparam logic [6:0] R_LHP    = 7'h02;
    localparam logic [6:0] R_RHP    = 7'h03;
    localparam logic [6:0] R_APATH  = 7'h04;
    localparam logic [6:0] R_DPATH  = 7'h05;
    localparam logic [6:0] R_PWR    = 7'h06;
    localparam logic [6:0] R_IFACE  = 7'h07;
    localparam logic [6:0] R_SRATE  = 7'h08;
    localparam logic [6:0] R_ACTIVE = 7'h09;
    localparam logic [6:0] R_RESET  = 7'h0F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BYTE,
        S_ACK,
        S_STOP,
        S_GAP,
        S_NEXT,
        S_DONE
    } state_t;

    // {reg[6:0], data[8:0]}; reset first, ACTIVE last so the codec only runs once configured.
    function automatic logic [15:0] cfg_word(input logic [3:0] idx);
        case (idx)
            4'd0:    cfg_word = {R_RESET,  9'h000};
            4'd1:    cfg_word = {R_LLIN,   9'h017};
            4'd2:    cfg_word = {R_LHP,    9'h079};
            4'd3:    cfg_word = {R_RHP,    9'h079};
            4'd4:    cfg_word = {R_APATH,  9'h012};
            4'd5:    cfg_word = {R_DPATH,  9'h000};
            4'd6:    cfg_word = {R_PWR,    9'h000};
            4'd7:    cfg_word = {R_IFACE,  9'h003};
            4'd8:    cfg_word = {R_SRATE,  9'h000};
            default: cfg_word = {R_ACTIVE, 9'h001};
        endcase
    endfunction

    function automatic logic [7:0] frame_byte(input logic [6:0] dev, input logic [3:0] idx,
                                              input logic [1:0] n);
        logic [15:0] w;
        w = cfg_word(idx);
        case (n)
            2'd0:    frame_byte = {dev, 1'b0};
            2'd1:    frame_byte = w[15:8];
            default: frame_byte = w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit tick generator: one-cycle pulse every DIV clocks while enabled.
module i2c_quarter_tick #(
    parameter int unsigned DIV = 125
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (!enable) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == CW'(DIV - 1)) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
        end
    end
endmodule

// File: rtl/codec_config_sequencer.sv
// Boot-time I2C master writing the 10-word WM8731 configuration table, with NACK retry.
module codec_config_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned I2C_HZ    = 100_000,
    parameter logic [6:0]  DEV_ADDR  = 7'h1A,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned GAP_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       sdat_in,
    output logic       i2c_sclk,
    output logic       sdat_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] reg_index
);
    localparam int unsigned DIV = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned GW  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    state_t        state;
    logic [1:0]    q;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [RW-1:0] retry;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    shreg;
    logic          armed;
    logic          nack;
    logic          abort;
    logic [1:0]    sda_sync;
    logic          tick;
    logic          tick_en;

    always_comb tick_en = (state != S_IDLE);

    i2c_quarter_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (tick_en),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sda_sync <= 2'b11;
        else          sda_sync <= {sda_sync[0], sdat_in};
    end

    // q is the quarter currently in progress; each tick performs the q -> q+1 edge action.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            q         <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            retry     <= '0;
            gap_cnt   <= '0;
            shreg     <= '0;
            armed     <= 1'b1;
            nack      <= 1'b0;
            abort     <= 1'b0;
            i2c_sclk  <= 1'b1;
            sdat_oe   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            reg_index <= '0;
        end else begin
            armed <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start || armed) begin
                        state     <= S_START;
                        q         <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        reg_index <= '0;
                        retry     <= '0;
                        nack      <= 1'b0;
                        abort     <= 1'b0;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    if (tick) begin
                        case (state)
                            S_START: begin
                                if (q == 2'd0) begin
                                    sdat_oe <= 1'b1;
                                    q       <= 2'd1;
                                end else begin
                                    i2c_sclk <= 1'b0;
                                    q        <= 2'd0;
                                    bit_cnt  <= '0;
                                    byte_cnt <= '0;
                                    shreg    <= frame_byte(DEV_ADDR, reg_index, 2'd0);
                                    state    <= S_BYTE;
                                end
                            end
                            S_BYTE: begin
                                q <= q + 2'd1;
                                case (q)
                                    2'd0: sdat_oe  <= ~shreg[7];
                                    2'd1: i2c_sclk <= 1'b1;
                                    2'd3: begin
                                        i2c_sclk <= 1'b0;
                                        shreg    <= {shreg[6:0], 1'b0};
                                        bit_cnt  <= bit_cnt + 3'd1;
                                        if (bit_cnt == 3'd7) state <= S_ACK;
                                    end
                                    default: ;
                                endcase
                            end
                            S_ACK: begin
                                q <= q + 2'd1;
                                case (q)
                                    2'd0: sdat_oe  <= 1'b0;
                                    2'd1: i2c_sclk <= 1'b1;
                                    2'd3: begin
                                        i2c_sclk <= 1'b0;
                                        if (sda_sync[1]) begin
                                            state <= S_STOP;
                                            nack  <= 1'b1;
                                            if (retry == RW'(MAX_RETRY)) abort <= 1'b1;
                                            else                         retry <= retry + 1'b1;
                                        end else if (byte_cnt == 2'd2) begin
                                            state <= S_STOP;
                                        end else begin
                                            byte_cnt <= byte_cnt + 2'd1;
                                            shreg    <= frame_byte(DEV_ADDR, reg_index, byte_cnt + 2'd1);
                                            state    <= S_BYTE;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            S_STOP: begin
                                q <= q + 2'd1;
                                case (q)
                                    2'd0: sdat_oe  <= 1'b1;
                                    2'd1: i2c_sclk <= 1'b1;
                                    2'd2: sdat_oe  <= 1'b0;
                                    default: begin
                                        if (abort) begin
                                            state <= S_IDLE;
                                            busy  <= 1'b0;
                                            error <= 1'b1;
                                        end else begin
                                            gap_cnt <= '0;
                                            state   <= S_GAP;
                                        end
                                    end
                                endcase
                            end
                            S_GAP: begin
                                gap_cnt <= gap_cnt + 1'b1;
                                if (gap_cnt == GW'(GAP_TICKS - 1)) state <= S_NEXT;
                            end
                            S_NEXT: begin
                                q <= '0;
                                if (nack) begin
                                    nack  <= 1'b0;
                                    state <= S_START;
                                end else if (reg_index == 4'(NUM_REGS - 1)) begin
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= S_DONE;
                                end else begin
                                    reg_index <= reg_index + 4'd1;
                                    retry     <= '0;
                                    state     <= S_START;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench: I2C slave model with NACK injection, frame capture and bus-timing checks.
module tb_codec_config_sequencer;
    localparam int unsigned DIV = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       sdat_in;
    logic       i2c_sclk;
    logic       sdat_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] reg_index;

    logic       slave_pull = 1'b0;
    logic       sda;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    assign sda     = !(sdat_oe || slave_pull);
    assign sdat_in = sda;

    codec_config_sequencer #(
        .CLK_HZ   (800_000),
        .I2C_HZ   (100_000),
        .DEV_ADDR (7'h1A),
        .MAX_RETRY(3),
        .GAP_TICKS(8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .sdat_in  (sdat_in),
        .i2c_sclk (i2c_sclk),
        .sdat_oe  (sdat_oe),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .reg_index(reg_index)
    );

    logic [7:0] exp_b1 [10] = '{8'h1E, 8'h00, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h10, 8'h12};
    logic [7:0] exp_b2 [10] = '{8'h00, 8'h17, 8'h79, 8'h79, 8'h12, 8'h00, 8'h00, 8'h03, 8'h00, 8'h01};

    // Slave model and bus monitor
    logic [7:0] nack_byte  = 8'h00;
    int         nack_limit = 0;
    int         nack_base  = 0;
    int         attempts [256];
    logic [7:0] fr_b0 [128];
    logic [7:0] fr_b1 [128];
    logic [7:0] fr_b2 [128];
    int         fr_n  [128];
    int         fcount = 0;
    int         proto_err = 0;
    int         low_phases = 0;
    logic [7:0] cur [3];
    logic [7:0] sh;
    int         bitpos, bytepos, low_len;
    bit         in_frame, prev_scl, prev_sda, nackit;

    initial for (int i = 0; i < 256; i++) attempts[i] = 0;

    always @(posedge clk) begin
        if (done && error) proto_err++;
        if (!reset_n) begin
            in_frame = 1'b0; bitpos = 0; bytepos = 0; low_len = 0;
            prev_scl = 1'b1; prev_sda = 1'b1;
            slave_pull <= 1'b0;
        end else begin
            if (!i2c_sclk) low_len++;
            if (prev_scl && i2c_sclk && prev_sda && !sda) begin
                if (in_frame) proto_err++;
                in_frame = 1'b1; bitpos = 0; bytepos = 0;
                cur[0] = 8'h00; cur[1] = 8'h00; cur[2] = 8'h00;
            end else if (prev_scl && i2c_sclk && !prev_sda && sda) begin
                if (!in_frame || bitpos != 1) proto_err++;
                if (in_frame && fcount < 128) begin
                    fr_b0[fcount] = cur[0]; fr_b1[fcount] = cur[1]; fr_b2[fcount] = cur[2];
                    fr_n[fcount] = bytepos;
                    fcount++;
                end
                in_frame = 1'b0;
            end else if (!prev_scl && i2c_sclk) begin
                if (low_len != 2 * DIV) proto_err++;
                low_phases++;
                low_len = 0;
                if (in_frame) begin
                    if (bitpos < 8) begin
                        sh = {sh[6:0], sda};
                        bitpos++;
                        if (bitpos == 8 && bytepos < 3) cur[bytepos] = sh;
                    end else begin
                        bitpos = 9;
                    end
                end
            end else if (prev_scl && !i2c_sclk && in_frame) begin
                if (bitpos == 8) begin
                    nackit = 1'b0;
                    if (bytepos == 1) begin
                        nackit = (cur[1] == nack_byte) && (attempts[cur[1]] - nack_base < nack_limit);
                        attempts[cur[1]]++;
                    end
                    slave_pull <= !nackit;
                end else if (bitpos == 9) begin
                    slave_pull <= 1'b0;
                    bitpos = 0;
                    bytepos++;
                end
            end
            prev_scl = i2c_sclk;
            prev_sda = sda;
        end
    end

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        n_chk += 6;
        if (i2c_sclk !== 1'b1) begin n_err++; $display("FAIL reset_sclk got=%b want=1", i2c_sclk); end
        if (sdat_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe got=%b want=0", sdat_oe); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
        if (error !== 1'b0) begin n_err++; $display("FAIL reset_error got=%b want=0", error); end
        if (reg_index !== 4'd0) begin n_err++; $display("FAIL reset_index got=%0d want=0", reg_index); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL autostart_busy got=%b want=1", busy); end
    endtask

    task automatic test_full_run();
        bit ok;
        int base;
        base = fcount;
        wait_idle(10000, ok);
        n_chk += 8;
        if (!ok) begin n_err++; $display("FAIL full_timeout busy=%b want=0", busy); end
        if (done !== 1'b1) begin n_err++; $display("FAIL full_done got=%b want=1", done); end
        if (error !== 1'b0) begin n_err++; $display("FAIL full_error got=%b want=0", error); end
        if (reg_index !== 4'd9) begin n_err++; $display("FAIL full_index got=%0d want=9", reg_index); end
        if (i2c_sclk !== 1'b1 || sdat_oe !== 1'b0) begin
            n_err++; $display("FAIL full_bus_idle sclk=%b oe=%b want 1/0", i2c_sclk, sdat_oe);
        end
        if (fcount - base != 10) begin n_err++; $display("FAIL full_frames got=%0d want=10", fcount - base); end
        if (proto_err != 0) begin n_err++; $display("FAIL protocol got=%0d violations want=0", proto_err); end
        if (low_phases < 100) begin n_err++; $display("FAIL scl_activity got=%0d want>=100", low_phases); end
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if ({fr_b0[base+i], fr_b1[base+i], fr_b2[base+i]} !== {8'h34, exp_b1[i], exp_b2[i]} ||
                fr_n[base+i] != 3) begin
                n_err++;
                $display("FAIL full_frame%0d got=%h %h %h n=%0d want=34 %h %h n=3", i,
                         fr_b0[base+i], fr_b1[base+i], fr_b2[base+i], fr_n[base+i], exp_b1[i], exp_b2[i]);
            end
        end
    endtask

    task automatic test_nack_retry();
        bit ok;
        int base, a0, full, part;
        nack_byte = 8'h08; nack_limit = 2; nack_base = attempts[8'h08];
        a0 = attempts[8'h08];
        base = fcount;
        pulse_start();
        n_chk += 2;
        if (busy !== 1'b1) begin n_err++; $display("FAIL retry_busy got=%b want=1", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL retry_done_clear got=%b want=0", done); end
        wait_idle(10000, ok);
        full = 0; part = 0;
        for (int i = base; i < fcount; i++) begin
            if (fr_n[i] == 3) full++;
            if (fr_n[i] == 2 && fr_b1[i] == 8'h08) part++;
        end
        n_chk += 6;
        if (!ok) begin n_err++; $display("FAIL retry_timeout busy=%b want=0", busy); end
        if (done !== 1'b1 || error !== 1'b0) begin
            n_err++; $display("FAIL retry_status done=%b error=%b want 1/0", done, error);
        end
        if (attempts[8'h08] - a0 != 3) begin
            n_err++; $display("FAIL retry_attempts got=%0d want=3", attempts[8'h08] - a0);
        end
        if (fcount - base != 12) begin n_err++; $display("FAIL retry_frames got=%0d want=12", fcount - base); end
        if (full != 10) begin n_err++; $display("FAIL retry_full got=%0d want=10", full); end
        if (part != 2) begin n_err++; $display("FAIL retry_nacked got=%0d want=2", part); end
        nack_limit = 0;
    endtask

    task automatic test_nack_abort();
        bit ok;
        int base, a0;
        nack_byte = 8'h04; nack_limit = 1000; nack_base = attempts[8'h04];
        a0 = attempts[8'h04];
        base = fcount;
        pulse_start();
        wait_idle(10000, ok);
        repeat (4) @(negedge clk);
        n_chk += 8;
        if (!ok) begin n_err++; $display("FAIL abort_timeout busy=%b want=0", busy); end
        if (error !== 1'b1) begin n_err++; $display("FAIL abort_error got=%b want=1", error); end
        if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got=%b want=0", done); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b want=0", busy); end
        if (reg_index !== 4'd2) begin n_err++; $display("FAIL abort_index got=%0d want=2", reg_index); end
        if (i2c_sclk !== 1'b1 || sdat_oe !== 1'b0) begin
            n_err++; $display("FAIL abort_bus sclk=%b oe=%b want 1/0", i2c_sclk, sdat_oe);
        end
        if (attempts[8'h04] - a0 != 4) begin
            n_err++; $display("FAIL abort_attempts got=%0d want=4", attempts[8'h04] - a0);
        end
        if (fcount - base != 6) begin n_err++; $display("FAIL abort_frames got=%0d want=6", fcount - base); end
        nack_limit = 0;
    endtask

    task automatic test_start_ignored();
        bit ok;
        int base;
        base = fcount;
        pulse_start();
        n_chk++;
        if (error !== 1'b0) begin n_err++; $display("FAIL start_clears_error got=%b want=0", error); end
        repeat (600) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_chk += 2;
        if (busy !== 1'b1) begin n_err++; $display("FAIL ignore_busy got=%b want=1", busy); end
        if (reg_index == 4'd0) begin n_err++; $display("FAIL ignore_index got=%0d want nonzero", reg_index); end
        wait_idle(10000, ok);
        n_chk += 2;
        if (!ok || done !== 1'b1) begin n_err++; $display("FAIL ignore_done ok=%b done=%b want 1/1", ok, done); end
        if (fcount - base != 10) begin n_err++; $display("FAIL ignore_frames got=%0d want=10", fcount - base); end
        base = fcount;
        pulse_start();
        n_chk += 2;
        if (done !== 1'b0) begin n_err++; $display("FAIL rerun_done_clear got=%b want=0", done); end
        if (busy !== 1'b1) begin n_err++; $display("FAIL rerun_busy got=%b want=1", busy); end
        wait_idle(10000, ok);
        n_chk += 2;
        if (!ok || done !== 1'b1) begin n_err++; $display("FAIL rerun_done ok=%b done=%b want 1/1", ok, done); end
        if (fcount - base != 10) begin n_err++; $display("FAIL rerun_frames got=%0d want=10", fcount - base); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok, found;
        int base;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (in_frame && bytepos == 2 && cur[1] == 8'h0A && sdat_oe === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!found) begin n_err++; $display("FAIL midreset_reach found=%b want=1", found); end
        #2;
        reset_n = 1'b0;
        #1;
        n_chk += 3;
        if (i2c_sclk !== 1'b1) begin n_err++; $display("FAIL midreset_sclk got=%b want=1", i2c_sclk); end
        if (sdat_oe !== 1'b0) begin n_err++; $display("FAIL midreset_oe got=%b want=0", sdat_oe); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy got=%b want=0", busy); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        base = fcount;
        @(negedge clk);
        wait_idle(10000, ok);
        n_chk += 3;
        if (!ok || done !== 1'b1) begin n_err++; $display("FAIL midreset_done ok=%b done=%b want 1/1", ok, done); end
        if (fcount - base != 10) begin n_err++; $display("FAIL midreset_frames got=%0d want=10", fcount - base); end
        if ({fr_b0[base], fr_b1[base], fr_b2[base]} !== 24'h341E00) begin
            n_err++; $display("FAIL midreset_first got=%h%h%h want=341e00", fr_b0[base], fr_b1[base], fr_b2[base]);
        end
        n_chk++;
        if (proto_err != 0) begin n_err++; $display("FAIL protocol_final got=%0d want=0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_nack_retry();
        test_nack_abort();
        test_start_ignored();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
